snake_game_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 52 +++++
 rtl/snake_game_ctrl_if.sv | 20 ++
 rtl/snake_cmd_decode.sv | 28 ++
 rtl/snake_game_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: state, direction and command encodings,
// PS/2 make codes and the direction-reversal helper.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED   = 2'd0,
        ST_PLAY     = 2'd1,
        ST_GAMEOVER = 2'd2,
        ST_BLACKOUT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_W = 2'd2,
        DIR_E = 2'd3
    } dir_e;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_START,
        CMD_PAUSE,
        CMD_RESUME,
        CMD_ESC,
        CMD_UP,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT
    } cmd_e;

    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    function automatic dir_e opposite(input dir_e d);
        dir_e o;
        o = d;
        unique case (d)
            DIR_N: o = DIR_S;
            DIR_S: o = DIR_N;
            DIR_W: o = DIR_E;
            DIR_E: o = DIR_W;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Key-input and pixel-query bundle between the PS/2 front end, the VGA mux
// and the snake engine.
interface snake_game_ctrl_if;
    logic       newKeyStrobe;
    logic [7:0] keycode;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       SnakeOut;
    logic       HeadOut;

    modport master (
        output newKeyStrobe, keycode, hcount, vcount,
        input  SnakeOut, HeadOut
    );

    modport slave (
        input  newKeyStrobe, keycode, hcount, vcount,
        output SnakeOut, HeadOut
    );
endinterface

// File: rtl/snake_cmd_decode.sv
// Turns a strobed PS/2 make code into a one-cycle game command; unknown
// codes and idle cycles decode to CMD_NONE.
module snake_cmd_decode
    import snake_pkg::*;
(
    input  logic       i_strobe,
    input  logic [7:0] i_keycode,
    output cmd_e       o_cmd
);

    always_comb begin
        o_cmd = CMD_NONE;
        if (i_strobe) begin
            case (i_keycode)
                KEY_S:     o_cmd = CMD_START;
                KEY_P:     o_cmd = CMD_PAUSE;
                KEY_R:     o_cmd = CMD_RESUME;
                KEY_ESC:   o_cmd = CMD_ESC;
                KEY_UP:    o_cmd = CMD_UP;
                KEY_DOWN:  o_cmd = CMD_DOWN;
                KEY_LEFT:  o_cmd = CMD_LEFT;
                KEY_RIGHT: o_cmd = CMD_RIGHT;
                default:   o_cmd = CMD_NONE;
            endcase
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Grid snake engine: game FSM, shifting body with growth, wall/self collision
// and a registered per-pixel snake/head query. Define SNAKE_WRAP_EN for wrapping walls.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int CELL_SHIFT = 3,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 4,
    parameter int START_X    = 40,
    parameter int START_Y    = 30
) (
    input  logic                         clk100MHz,
    input  logic                         rst_n,
    input  logic                         step_tick,
    input  logic                         grow,
    snake_game_ctrl_if.slave             bus,
    output logic [1:0]                   game_state,
    output logic [$clog2(GRID_W)-1:0]    head_x,
    output logic [$clog2(GRID_H)-1:0]    head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] snake_len
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    state_e        r_state, w_state_nxt;
    dir_e          r_dir, r_pend_dir, w_arrow_dir;
    logic [LW-1:0] r_len;
    logic          r_grow_pend;
    logic [XW-1:0] r_seg_x [MAX_LEN];
    logic [YW-1:0] r_seg_y [MAX_LEN];
    logic          r_snake_out, r_head_out;

    cmd_e          w_cmd;
    logic          w_init, w_step, w_arrow_ok, w_is_arrow;
    logic          w_wall, w_self, w_die, w_grows;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [9:0]    w_cx, w_cy;
    logic          w_on_grid, w_hit, w_head_hit;

    snake_cmd_decode u_cmd_decode (
        .i_strobe  (bus.newKeyStrobe),
        .i_keycode (bus.keycode),
        .o_cmd     (w_cmd)
    );

    function automatic logic [XW-1:0] init_x(input int unsigned i);
        return (int'(i) < INIT_LEN) ? XW'(START_X - int'(i)) : '0;
    endfunction

    function automatic logic [YW-1:0] init_y(input int unsigned i);
        return (int'(i) < INIT_LEN) ? YW'(START_Y) : '0;
    endfunction

    // Edge compares instead of signed arithmetic so coordinates never underflow.
    always_comb begin
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        unique case (r_pend_dir)
            DIR_N: if (r_seg_y[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                w_ny = YW'(GRID_H - 1);
`else
                w_wall = 1'b1;
`endif
            end else w_ny = r_seg_y[0] - YW'(1);
            DIR_S: if (r_seg_y[0] == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                w_ny = '0;
`else
                w_wall = 1'b1;
`endif
            end else w_ny = r_seg_y[0] + YW'(1);
            DIR_W: if (r_seg_x[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                w_nx = XW'(GRID_W - 1);
`else
                w_wall = 1'b1;
`endif
            end else w_nx = r_seg_x[0] - XW'(1);
            DIR_E: if (r_seg_x[0] == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                w_nx = '0;
`else
                w_wall = 1'b1;
`endif
            end else w_nx = r_seg_x[0] + XW'(1);
        endcase
    end

    // The tail only blocks the head when it stays put, i.e. when the snake really grows.
    always_comb begin
        w_grows = r_grow_pend && (r_len != LW'(MAX_LEN));
        w_self  = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny) &&
                ((i + 1 < 32'(r_len)) || (w_grows && (i + 1 == 32'(r_len)))))
                w_self = 1'b1;
        end
        w_die = w_wall || w_self;
    end

    always_comb begin
        w_is_arrow  = 1'b1;
        w_arrow_dir = r_dir;
        case (w_cmd)
            CMD_UP:    w_arrow_dir = DIR_N;
            CMD_DOWN:  w_arrow_dir = DIR_S;
            CMD_LEFT:  w_arrow_dir = DIR_W;
            CMD_RIGHT: w_arrow_dir = DIR_E;
            default:   w_is_arrow  = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_step      = 1'b0;
        w_arrow_ok  = 1'b0;
        unique case (r_state)
            ST_BLACKOUT: begin
                if (w_cmd == CMD_START) begin
                    w_init      = 1'b1;
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                case (w_cmd)
                    CMD_START: w_init      = 1'b1;
                    CMD_PAUSE: w_state_nxt = ST_PAUSED;
                    CMD_ESC:   w_state_nxt = ST_BLACKOUT;
                    default: begin
                        w_step = step_tick;
                        if (step_tick && w_die)
                            w_state_nxt = ST_GAMEOVER;
                        // Legality is judged against the direction in force once this cycle's step lands.
                        if (w_is_arrow && (w_arrow_dir != opposite(step_tick ? r_pend_dir : r_dir)))
                            w_arrow_ok = 1'b1;
                    end
                endcase
            end
            ST_PAUSED: begin
                case (w_cmd)
                    CMD_RESUME: w_state_nxt = ST_PLAY;
                    CMD_START: begin
                        w_init      = 1'b1;
                        w_state_nxt = ST_PLAY;
                    end
                    CMD_ESC: w_state_nxt = ST_BLACKOUT;
                    default: ;
                endcase
            end
            ST_GAMEOVER: begin
                case (w_cmd)
                    CMD_START: begin
                        w_init      = 1'b1;
                        w_state_nxt = ST_PLAY;
                    end
                    CMD_ESC: w_state_nxt = ST_BLACKOUT;
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) r_state <= ST_BLACKOUT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_dir       <= DIR_E;
            r_pend_dir  <= DIR_E;
            r_len       <= LW'(INIT_LEN);
            r_grow_pend <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_x(i);
                r_seg_y[i] <= init_y(i);
            end
        end else if (w_init) begin
            r_dir       <= DIR_E;
            r_pend_dir  <= DIR_E;
            r_len       <= LW'(INIT_LEN);
            r_grow_pend <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= init_x(i);
                r_seg_y[i] <= init_y(i);
            end
        end else begin
            if (w_step && !w_die) begin
                r_dir      <= r_pend_dir;
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                if (w_grows) r_len <= r_len + LW'(1);
            end
            if (w_arrow_ok) r_pend_dir <= w_arrow_dir;
            if (grow)                      r_grow_pend <= 1'b1;
            else if (w_step && !w_die)     r_grow_pend <= 1'b0;
        end
    end

    assign w_cx      = bus.hcount >> CELL_SHIFT;
    assign w_cy      = bus.vcount >> CELL_SHIFT;
    assign w_on_grid = (w_cx < 10'(GRID_W)) && (w_cy < 10'(GRID_H));

    always_comb begin
        w_hit      = 1'b0;
        w_head_hit = (10'(r_seg_x[0]) == w_cx) && (10'(r_seg_y[0]) == w_cy);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((i < 32'(r_len)) && (10'(r_seg_x[i]) == w_cx) && (10'(r_seg_y[i]) == w_cy))
                w_hit = 1'b1;
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_snake_out <= 1'b0;
            r_head_out  <= 1'b0;
        end else begin
            r_snake_out <= (r_state != ST_BLACKOUT) && w_on_grid && w_hit;
            r_head_out  <= (r_state != ST_BLACKOUT) && w_on_grid && w_head_hit;
        end
    end

    assign bus.SnakeOut = r_snake_out;
    assign bus.HeadOut  = r_head_out;
    assign game_state   = r_state;
    assign head_x       = r_seg_x[0];
    assign head_y       = r_seg_y[0];
    assign snake_len    = r_len;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: queue-based snake model compared every cycle, plus
// directed literal checks. Honours SNAKE_WRAP_EN like the design.
module tb_snake_game_ctrl;

    localparam int W = 80, H = 60, CS = 3, ML = 16, IL = 4, SX = 40, SY = 30;
    localparam logic [7:0] K_S = 8'h1B, K_P = 8'h4D, K_R = 8'h2D, K_ESC = 8'h76;
    localparam logic [7:0] K_UP = 8'h75, K_DN = 8'h72, K_LT = 8'h6B, K_RT = 8'h74;

    logic       clk100MHz = 1'b0;
    logic       rst_n = 1'b1;
    logic       step_tick = 1'b0;
    logic       grow = 1'b0;
    logic [1:0] game_state;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [4:0] snake_len;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .GRID_W(W), .GRID_H(H), .CELL_SHIFT(CS), .MAX_LEN(ML),
        .INIT_LEN(IL), .START_X(SX), .START_Y(SY)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .step_tick (step_tick),
        .grow      (grow),
        .bus       (bus),
        .game_state(game_state),
        .head_x    (head_x),
        .head_y    (head_y),
        .snake_len (snake_len)
    );

    initial forever #5 clk100MHz = ~clk100MHz;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit fix_px = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: body is a queue of cells, head at the front; dirs 0=N 1=S 2=W 3=E.
    typedef struct { int x; int y; } cell_t;
    cell_t body[$];
    int m_state, m_dir, m_pend, m_grow, m_so, m_ho;

    function automatic int dx(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic int cmd_of(input logic s, input logic [7:0] k);
        if (!s) return 0;
        case (k)
            K_S: return 1;   K_P: return 2;  K_R: return 3;  K_ESC: return 4;
            K_UP: return 5;  K_DN: return 6; K_LT: return 7; K_RT: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic model_init();
        cell_t c;
        body.delete();
        for (int k = 0; k < IL; k++) begin
            c.x = SX - k;
            c.y = SY;
            body.push_back(c);
        end
        m_dir = 3; m_pend = 3; m_grow = 0;
    endtask

    task automatic model_step();
        int nx, ny;
        bit dead, growing;
        cell_t c;
        nx = body[0].x + dx(m_pend);
        ny = body[0].y + dy(m_pend);
        dead = 1'b0;
`ifdef SNAKE_WRAP_EN
        nx = (nx + W) % W;
        ny = (ny + H) % H;
`else
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) dead = 1'b1;
`endif
        growing = (m_grow != 0) && (body.size() < ML);
        for (int k = 1; k < body.size(); k++)
            if (body[k].x == nx && body[k].y == ny && (k < body.size() - 1 || growing))
                dead = 1'b1;
        if (dead) m_state = 2;
        else begin
            m_dir = m_pend;
            c.x = nx;
            c.y = ny;
            body.push_front(c);
            if (!growing) void'(body.pop_back());
            m_grow = 0;
        end
    endtask

    task automatic model_cycle();
        int c, st0, cx, cy;
        c   = cmd_of(bus.newKeyStrobe, bus.keycode);
        st0 = m_state;
        cx  = int'(bus.hcount) / (1 << CS);
        cy  = int'(bus.vcount) / (1 << CS);
        m_so = 0;
        m_ho = 0;
        if (st0 != 3 && cx < W && cy < H) begin
            foreach (body[k]) if (body[k].x == cx && body[k].y == cy) m_so = 1;
            m_ho = (body[0].x == cx && body[0].y == cy) ? 1 : 0;
        end
        if (st0 == 1 && step_tick && c != 1 && c != 2 && c != 4) model_step();
        if (grow) m_grow = 1;
        case (c)
            1: begin model_init(); m_state = 1; end
            2: if (st0 == 1) m_state = 0;
            3: if (st0 == 0) m_state = 1;
            4: m_state = 3;
            5, 6, 7, 8: if (st0 == 1 && (c - 5) != (m_dir ^ 1)) m_pend = c - 5;
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk100MHz or negedge rst_n);
        if (!rst_n) begin
            model_init();
            m_state = 3; m_so = 0; m_ho = 0;
        end else model_cycle();
    end

    initial forever begin
        @(negedge clk100MHz);
        if (chk_en) begin
            cmp("game_state", int'(game_state), m_state);
            cmp("head_x", int'(head_x), body[0].x);
            cmp("head_y", int'(head_y), body[0].y);
            cmp("snake_len", int'(snake_len), body.size());
            cmp("SnakeOut", int'(bus.SnakeOut), m_so);
            cmp("HeadOut", int'(bus.HeadOut), m_ho);
        end
    end

    task automatic rand_px();
        int k;
        if ($urandom_range(1, 0) == 1) begin
            k = $urandom_range(body.size() - 1, 0);
            bus.hcount = 10'(body[k].x * 8 + int'($urandom_range(7, 0)));
            bus.vcount = 10'(body[k].y * 8 + int'($urandom_range(7, 0)));
        end else begin
            bus.hcount = 10'($urandom_range(1023, 0));
            bus.vcount = 10'($urandom_range(1023, 0));
        end
    endtask

    task automatic tick_cycle(input logic kv, input logic [7:0] kc, input logic tk, input logic gr);
        bus.newKeyStrobe = kv;
        bus.keycode      = kc;
        step_tick        = tk;
        grow             = gr;
        if (!fix_px) rand_px();
        @(posedge clk100MHz);
        #1;
        bus.newKeyStrobe = 1'b0;
        step_tick        = 1'b0;
        grow             = 1'b0;
    endtask

    task automatic key(input logic [7:0] kc);  tick_cycle(1'b1, kc, 1'b0, 1'b0); endtask
    task automatic step();                      tick_cycle(1'b0, 8'h00, 1'b1, 1'b0); endtask
    task automatic idle();                      tick_cycle(1'b0, 8'h00, 1'b0, 1'b0); endtask
    task automatic pulse_grow();                tick_cycle(1'b0, 8'h00, 1'b0, 1'b1); endtask

    task automatic set_px(input int h, input int v);
        fix_px = 1'b1;
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.newKeyStrobe = 1'b0;
        bus.keycode      = 8'h00;
        bus.hcount       = '0;
        bus.vcount       = '0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk100MHz);
        #1 rst_n = 1'b1;
        cmp("rst_state", int'(game_state), 3);
        cmp("rst_len", int'(snake_len), 4);
        cmp("rst_head_x", int'(head_x), 40);
        cmp("rst_snake", int'(bus.SnakeOut), 0);

        key(K_S);
        cmp("start_state", int'(game_state), 1);
        repeat (3) step();
        cmp("run_head_x", int'(head_x), 43);
        cmp("run_head_y", int'(head_y), 30);
        cmp("run_len", int'(snake_len), 4);
        set_px(43 * 8, 30 * 8);
        idle();
        cmp("px_snake", int'(bus.SnakeOut), 1);
        cmp("px_head", int'(bus.HeadOut), 1);
        fix_px = 1'b0;

        key(K_LT); step();
        cmp("rev_head_x", int'(head_x), 44);
        key(K_UP); step();
        cmp("up_head_y", int'(head_y), 29);

        pulse_grow(); step();
        cmp("grow_len", int'(snake_len), 5);
        set_px(42 * 8 + 5, 30 * 8 + 7);
        idle();
        cmp("tail_snake", int'(bus.SnakeOut), 1);
        cmp("tail_head", int'(bus.HeadOut), 0);
        fix_px = 1'b0;
        repeat (13) begin pulse_grow(); step(); end
        cmp("sat_len", int'(snake_len), 16);
        cmp("sat_head_y", int'(head_y), 15);

        key(K_RT);
        repeat (35) step();
        cmp("edge_head_x", int'(head_x), 79);
        step();
`ifdef SNAKE_WRAP_EN
        cmp("wall_head_x", int'(head_x), 0);
        cmp("wall_state", int'(game_state), 1);
`else
        cmp("wall_head_x", int'(head_x), 79);
        cmp("wall_state", int'(game_state), 2);
`endif
        cmp("wall_head_y", int'(head_y), 15);

        key(K_S);
        cmp("init_head_x", int'(head_x), 40);
        pulse_grow(); step();
        key(K_UP); step();
        key(K_LT); step();
        key(K_DN); step();
        cmp("self_state", int'(game_state), 2);
        cmp("self_head_x", int'(head_x), 40);
        cmp("self_head_y", int'(head_y), 29);
        key(K_S);
        cmp("restart_state", int'(game_state), 1);
        cmp("restart_len", int'(snake_len), 4);

        key(K_P);
        repeat (5) step();
        cmp("pause_state", int'(game_state), 0);
        cmp("pause_head_x", int'(head_x), 40);
        key(K_R); step();
        cmp("resume_head_x", int'(head_x), 41);
        tick_cycle(1'b1, K_DN, 1'b1, 1'b0);
        cmp("arrow_tick_x", int'(head_x), 42);
        step();
        cmp("arrow_next_y", int'(head_y), 31);

        key(K_ESC);
        cmp("esc_state", int'(game_state), 3);
        for (int cy = 0; cy < H; cy++)
            for (int cx = 0; cx < W; cx++) begin
                set_px(cx * 8 + (cx % 8), cy * 8 + (cy % 8));
                idle();
            end
        cmp("esc_snake", int'(bus.SnakeOut), 0);
        fix_px = 1'b0;

        key(K_S); step(); step();
        cmp("pre_rst_x", int'(head_x), 42);
        step_tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_state", int'(game_state), 3);
        cmp("midrst_len", int'(snake_len), 4);
        cmp("midrst_head_x", int'(head_x), 40);
        @(posedge clk100MHz); #1 step_tick = 1'b0;
        @(posedge clk100MHz); #1 rst_n = 1'b1;

        key(K_S); key(K_DN);
        repeat (3) step();
        cmp("final_head_y", int'(head_y), 33);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
